// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU arbiter slice.
// Holds the RV32 load/store funct3 encodings, requester ids and the request payload.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // A request expects load data back only when it is not a store.
  function automatic logic is_load_req(input lsu_req_t req);
    return !req.we;
  endfunction

endpackage

// File: rtl/lsu_arb_resp_pipe.sv
// Response tracker for the LSU arbiter: remembers which requester owns each
// issued access and whether it was a load, delayed by RD_LAT cycles so the
// tag lines up with the LSU read data.
module lsu_arb_resp_pipe
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    valid_i,
  input  req_id_e owner_i,
  input  logic    is_load_i,
  output logic    valid_o,
  output req_id_e owner_o,
  output logic    is_load_o
);

  if (RD_LAT == 0) begin : g_comb
    // Zero latency: the response belongs to the access issued this cycle.
    assign valid_o   = valid_i & rst_ni;
    assign owner_o   = owner_i;
    assign is_load_o = is_load_i;
  end else begin : g_reg
    logic    valid_q;
    req_id_e owner_q;
    logic    isLoad_q;

    // One-deep tag stage; reset drops any access still waiting for its data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q  <= 1'b0;
        owner_q  <= REQ_CORE;
        isLoad_q <= 1'b0;
      end else begin
        valid_q  <= valid_i;
        owner_q  <= owner_i;
        isLoad_q <= is_load_i;
      end
    end

    assign valid_o   = valid_q;
    assign owner_o   = owner_q;
    assign is_load_o = isLoad_q;
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of a single LSU port (m0 = core, m1 = DMA/loader).
// Grants are combinational in the request cycle; responses return RD_LAT cycles later.
// Default build: m0 priority with a starvation guard for m1 (STARVE_LIM).
// Define LSU_ARB_RR_EN to switch to plain round-robin arbitration instead.
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int STARVE_LIM = 8,
  parameter int RD_LAT     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [2:0]  m0_funct3_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [2:0]  m1_funct3_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        lsu_wren_o,
  output logic [2:0]  lsu_funct3_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  input  logic [31:0] lsu_ld_data_i
);

  lsu_req_t m0Req;
  lsu_req_t m1Req;
  lsu_req_t selReq;
  logic     m1Wins;
  logic     m0Gnt;
  logic     m1Gnt;
  req_id_e  gntId;
  logic     respValid;
  req_id_e  respOwner;
  logic     respIsLoad;

  assign m0Req = '{we: m0_we_i, funct3: m0_funct3_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1Req = '{we: m1_we_i, funct3: m1_funct3_i, addr: m1_addr_i, wdata: m1_wdata_i};

`ifdef LSU_ARB_RR_EN
  req_id_e lastGnt_q;
  req_id_e lastGnt_d;

  // On contention the requester that did not win last time goes next.
  assign m1Wins = (lastGnt_q == REQ_CORE);

  // Track who was granted most recently; idle cycles leave it unchanged.
  always_comb begin
    lastGnt_d = lastGnt_q;
    if (m0Gnt) lastGnt_d = REQ_CORE;
    if (m1Gnt) lastGnt_d = REQ_DMA;
  end

  // Pointer starts at m1 so the first contended cycle goes to m0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lastGnt_q <= REQ_DMA;
    else         lastGnt_q <= lastGnt_d;
  end
`else
  localparam logic [7:0] StarveLimC = 8'(STARVE_LIM);

  logic [7:0] waitCnt_q;
  logic [7:0] waitCnt_d;

  // m1 overrides core priority once it has waited long enough.
  assign m1Wins = (waitCnt_q >= StarveLimC);

  // Count consecutive cycles m1 is held off; saturate instead of wrapping.
  always_comb begin
    waitCnt_d = 8'd0;
    if (m1_req_i && !m1Gnt) begin
      waitCnt_d = (waitCnt_q == 8'hFF) ? waitCnt_q : waitCnt_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) waitCnt_q <= 8'd0;
    else         waitCnt_q <= waitCnt_d;
  end
`endif

  // Pick at most one winner; nothing is granted while reset is held.
  always_comb begin
    m0Gnt = 1'b0;
    m1Gnt = 1'b0;
    if (rst_ni) begin
      if (m0_req_i && m1_req_i) begin
        m1Gnt = m1Wins;
        m0Gnt = !m1Wins;
      end else begin
        m0Gnt = m0_req_i;
        m1Gnt = m1_req_i;
      end
    end
  end

  // Route the winner's payload to the LSU; an idle port drives all zeros.
  always_comb begin
    selReq = '0;
    gntId  = REQ_CORE;
    if (m1Gnt) begin
      selReq = m1Req;
      gntId  = REQ_DMA;
    end else if (m0Gnt) begin
      selReq = m0Req;
    end
  end

  assign m0_gnt_o      = m0Gnt;
  assign m1_gnt_o      = m1Gnt;
  assign lsu_wren_o    = selReq.we;
  assign lsu_funct3_o  = selReq.funct3;
  assign lsu_addr_o    = selReq.addr;
  assign lsu_st_data_o = selReq.wdata;

  lsu_arb_resp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_resp_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (m0Gnt | m1Gnt),
    .owner_i   (gntId),
    .is_load_i (is_load_req(selReq)),
    .valid_o   (respValid),
    .owner_o   (respOwner),
    .is_load_o (respIsLoad)
  );

  assign m0_rvalid_o = rst_ni & respValid & (respOwner == REQ_CORE);
  assign m1_rvalid_o = rst_ni & respValid & (respOwner == REQ_DMA);
  assign m0_rdata_o  = (m0_rvalid_o && respIsLoad) ? lsu_ld_data_i : 32'd0;
  assign m1_rdata_o  = (m1_rvalid_o && respIsLoad) ? lsu_ld_data_i : 32'd0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural
// model. Honours LSU_ARB_RR_EN when the build defines it.
module tb_lsu_arbiter;
  import lsu_pkg::*;

  localparam int STARVE_LIM = 8;
  localparam int RD_LAT     = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [2:0]  m0_funct3_i = '0;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [2:0]  m1_funct3_i = '0;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic [31:0] lsu_ld_data_i = '0;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o, lsu_wren_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, lsu_addr_o, lsu_st_data_o;
  logic [2:0]  lsu_funct3_o;

  int   vectors = 0;
  int   miscompares = 0;
  logic expGnt0 = 1'b0;
  logic expGnt1 = 1'b0;

  always #5 clk_i = ~clk_i;

  lsu_arbiter #(
    .STARVE_LIM (STARVE_LIM),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .m0_req_i      (m0_req_i),
    .m0_we_i       (m0_we_i),
    .m0_funct3_i   (m0_funct3_i),
    .m0_addr_i     (m0_addr_i),
    .m0_wdata_i    (m0_wdata_i),
    .m0_gnt_o      (m0_gnt_o),
    .m0_rvalid_o   (m0_rvalid_o),
    .m0_rdata_o    (m0_rdata_o),
    .m1_req_i      (m1_req_i),
    .m1_we_i       (m1_we_i),
    .m1_funct3_i   (m1_funct3_i),
    .m1_addr_i     (m1_addr_i),
    .m1_wdata_i    (m1_wdata_i),
    .m1_gnt_o      (m1_gnt_o),
    .m1_rvalid_o   (m1_rvalid_o),
    .m1_rdata_o    (m1_rdata_o),
    .lsu_wren_o    (lsu_wren_o),
    .lsu_funct3_o  (lsu_funct3_o),
    .lsu_addr_o    (lsu_addr_o),
    .lsu_st_data_o (lsu_st_data_o),
    .lsu_ld_data_i (lsu_ld_data_i)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic lsu_req_t mk(input logic isStore, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d);
    lsu_req_t r;
    r.we     = isStore;
    r.funct3 = f3;
    r.addr   = a;
    r.wdata  = d;
    return r;
  endfunction

  function automatic lsu_req_t randReq();
    logic       st;
    logic [2:0] f3;
    st = 1'($urandom_range(0, 1));
    if (st) begin
      case ($urandom_range(0, 2))
        0:       f3 = SB;
        1:       f3 = SH;
        default: f3 = SW;
      endcase
    end else begin
      case ($urandom_range(0, 4))
        0:       f3 = LB;
        1:       f3 = LH;
        2:       f3 = LW;
        3:       f3 = LBU;
        default: f3 = LHU;
      endcase
    end
    return mk(st, f3, $urandom(), $urandom());
  endfunction

  // Drive one cycle of requests just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic r0, input lsu_req_t q0, input logic r1,
                               input lsu_req_t q1, input logic [31:0] ld);
    @(posedge clk_i);
    #1;
    m0_req_i = r0; m0_we_i = q0.we; m0_funct3_i = q0.funct3; m0_addr_i = q0.addr; m0_wdata_i = q0.wdata;
    m1_req_i = r1; m1_we_i = q1.we; m1_funct3_i = q1.funct3; m1_addr_i = q1.addr; m1_wdata_i = q1.wdata;
    lsu_ld_data_i = ld;
    @(negedge clk_i);
  endtask

  // Behavioural model: who should win, what the LSU sees, and a queue of
  // responses each stamped with the cycle in which it must come back.
  typedef struct {
    int   due;
    logic toM1;
    logic isLoad;
  } resp_t;

  resp_t respQ[$];
  int    cycleNo = 0;
  int    waitCycles = 0;
  logic  lastWasM1 = 1'b1;

  always @(negedge clk_i) begin : compare
    logic        eg0, eg1, m1Win, ev0, ev1;
    logic [31:0] er0, er1, eAddr, eData;
    logic [2:0]  eF3;
    logic        eWe;
    resp_t       r;
    eg0 = 1'b0; eg1 = 1'b0; ev0 = 1'b0; ev1 = 1'b0; er0 = '0; er1 = '0;
    if (!rst_ni) begin
      respQ.delete();
      waitCycles = 0;
      lastWasM1  = 1'b1;
    end else begin
`ifdef LSU_ARB_RR_EN
      m1Win = !lastWasM1;
`else
      m1Win = (waitCycles >= STARVE_LIM);
`endif
      eg0 = m0_req_i && !(m1_req_i && m1Win);
      eg1 = m1_req_i && !eg0;
    end
    eWe = 1'b0; eF3 = '0; eAddr = '0; eData = '0;
    if (eg1) begin
      eWe = m1_we_i; eF3 = m1_funct3_i; eAddr = m1_addr_i; eData = m1_wdata_i;
    end else if (eg0) begin
      eWe = m0_we_i; eF3 = m0_funct3_i; eAddr = m0_addr_i; eData = m0_wdata_i;
    end
    if (eg0 || eg1) respQ.push_back('{due: cycleNo + RD_LAT, toM1: eg1, isLoad: !eWe});
    while (respQ.size() > 0 && respQ[0].due < cycleNo) void'(respQ.pop_front());
    if (respQ.size() > 0 && respQ[0].due == cycleNo) begin
      r = respQ.pop_front();
      if (r.toM1) begin ev1 = 1'b1; er1 = r.isLoad ? lsu_ld_data_i : 32'd0; end
      else        begin ev0 = 1'b1; er0 = r.isLoad ? lsu_ld_data_i : 32'd0; end
    end
    expGnt0 = eg0;
    expGnt1 = eg1;
    checkOutput("m0_gnt", {31'd0, m0_gnt_o}, {31'd0, eg0});
    checkOutput("m1_gnt", {31'd0, m1_gnt_o}, {31'd0, eg1});
    checkOutput("lsu_wren", {31'd0, lsu_wren_o}, {31'd0, eWe});
    checkOutput("lsu_funct3", {29'd0, lsu_funct3_o}, {29'd0, eF3});
    checkOutput("lsu_addr", lsu_addr_o, eAddr);
    checkOutput("lsu_st_data", lsu_st_data_o, eData);
    checkOutput("m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, ev0});
    checkOutput("m1_rvalid", {31'd0, m1_rvalid_o}, {31'd0, ev1});
    checkOutput("m0_rdata", m0_rdata_o, er0);
    checkOutput("m1_rdata", m1_rdata_o, er1);
    if (rst_ni) begin
      if (m1_req_i && !eg1) waitCycles = (waitCycles < 255) ? waitCycles + 1 : 255;
      else                  waitCycles = 0;
      if (eg1)      lastWasM1 = 1'b1;
      else if (eg0) lastWasM1 = 1'b0;
    end
    cycleNo++;
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    lsu_req_t idle;
    lsu_req_t q0;
    lsu_req_t q1;
    logic     exp1;
    idle = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Continuous contention straight out of reset.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, mk(1'b0, LW, 32'h0000_0100, 32'd0), 1'b1, mk(1'b0, LW, 32'h0000_0200, 32'd0), 32'd0);
`ifdef LSU_ARB_RR_EN
      exp1 = (c % 2) == 1;
`else
      exp1 = (c == 8);
`endif
      checkOutput("contend_m1_gnt", {31'd0, m1_gnt_o}, {31'd0, exp1});
      checkOutput("contend_m0_gnt", {31'd0, m0_gnt_o}, {31'd0, !exp1});
    end
    applyStimulus(1'b0, idle, 1'b0, idle, 32'd0);

    // Single core load with one cycle of read latency.
    applyStimulus(1'b1, mk(1'b0, LW, 32'h0001_0000, 32'd0), 1'b0, idle, 32'd0);
    checkOutput("ld_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    checkOutput("ld_lsu_addr", lsu_addr_o, 32'h0001_0000);
    checkOutput("ld_lsu_wren", {31'd0, lsu_wren_o}, 32'd0);
    applyStimulus(1'b0, idle, 1'b0, idle, 32'hDEAD_BEEF);
    checkOutput("ld_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd1);
    checkOutput("ld_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    checkOutput("ld_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
    checkOutput("ld_m1_rdata", m1_rdata_o, 32'd0);

    // DMA store then core reads of the same word.
    applyStimulus(1'b0, idle, 1'b1, mk(1'b1, SW, 32'h0002_0000, 32'h1234_5678), 32'd0);
    checkOutput("st_lsu_wren", {31'd0, lsu_wren_o}, 32'd1);
    checkOutput("st_lsu_data", lsu_st_data_o, 32'h1234_5678);
    applyStimulus(1'b1, mk(1'b0, LW, 32'h0002_0000, 32'd0), 1'b0, idle, 32'hFFFF_FFFF);
    checkOutput("st_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd1);
    checkOutput("st_m1_rdata", m1_rdata_o, 32'd0);
    applyStimulus(1'b1, mk(1'b0, LHU, 32'h0002_0000, 32'd0), 1'b0, idle, 32'h1234_5678);
    checkOutput("rd_lw_data", m0_rdata_o, 32'h1234_5678);
    applyStimulus(1'b0, idle, 1'b0, idle, 32'h0000_5678);
    checkOutput("rd_lhu_data", m0_rdata_o, 32'h0000_5678);

`ifndef LSU_ARB_RR_EN
    // m1 gives up after three lost cycles; its wait history must be forgotten.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, mk(1'b0, LW, 32'h0000_0300, 32'd0), 1'b1, mk(1'b1, SH, 32'h0000_0400, 32'h55), 32'd0);
      checkOutput("drop_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    end
    applyStimulus(1'b1, mk(1'b0, LW, 32'h0000_0300, 32'd0), 1'b0, idle, 32'd0);
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b1, mk(1'b0, LW, 32'h0000_0300, 32'd0), 1'b1, mk(1'b1, SH, 32'h0000_0400, 32'h55), 32'd0);
      checkOutput("rewait_m1_gnt", {31'd0, m1_gnt_o}, {31'd0, c == 8});
    end
    applyStimulus(1'b0, idle, 1'b0, idle, 32'd0);
`endif

    // Reset while a load response is in flight.
    applyStimulus(1'b1, mk(1'b0, LW, 32'h0003_0000, 32'd0), 1'b0, idle, 32'd0);
    checkOutput("rst_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    #1;
    rst_ni = 1'b0;
    m0_req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
    checkOutput("rst_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    lsu_ld_data_i = 32'hAAAA_AAAA;
    @(negedge clk_i);
    checkOutput("post_rst_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
    checkOutput("post_rst_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);

    // Random traffic: payloads held until granted, occasional drops and resets.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk_i);
      #1;
      rst_ni = ($urandom_range(0, 249) != 0);
      if (!m0_req_i || expGnt0) begin
        q0 = randReq();
        m0_req_i = ($urandom_range(0, 3) != 0);
        m0_we_i = q0.we; m0_funct3_i = q0.funct3; m0_addr_i = q0.addr; m0_wdata_i = q0.wdata;
      end else if ($urandom_range(0, 19) == 0) begin
        m0_req_i = 1'b0;
      end
      if (!m1_req_i || expGnt1) begin
        q1 = randReq();
        m1_req_i = ($urandom_range(0, 4) < 3);
        m1_we_i = q1.we; m1_funct3_i = q1.funct3; m1_addr_i = q1.addr; m1_wdata_i = q1.wdata;
      end else if ($urandom_range(0, 29) == 0) begin
        m1_req_i = 1'b0;
      end
      lsu_ld_data_i = $urandom();
    end
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 8: max consecutive cycles m1 may wait with m1_req_i high before forced grant (range 1..255).
REQ-002 SHALL have parameter RD_LAT, default 1: cycles from LSU address issue to valid lsu_ld_data_i (legal values 0, 1).
REQ-003 clk_i  in  1  clock, all state rising-edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 mN_req_i  in  1  requester N (N=0 core, N=1 DMA/loader) access request, held with payload stable until mN_gnt_o.
REQ-006 mN_we_i  in  1  store when 1, load when 0.
REQ-007 mN_funct3_i  in  3  RV32 load/store funct3.
REQ-008 mN_addr_i  in  32  byte address.
REQ-009 mN_wdata_i  in  32  store data.
REQ-010 mN_gnt_o  out  1  request accepted this cycle.
REQ-011 mN_rvalid_o  out  1  response for one earlier granted request.
REQ-012 mN_rdata_o  out  32  load data; 0 for store responses.
REQ-013 lsu_wren_o, lsu_funct3_o[2:0], lsu_addr_o[31:0], lsu_st_data_o[31:0]  out  drive LSU.
REQ-014 lsu_ld_data_i  in  32  LSU load data.

Function
REQ-015 At most one mN_gnt_o SHALL be high per cycle; grant is combinational in the cycle of request (zero-cycle accept).
REQ-016 Granted requester payload SHALL drive lsu_* in the grant cycle; with no grant, lsu_wren_o=0, lsu_addr_o=0, lsu_funct3_o=0, lsu_st_data_o=0 (addr 0 selects no memory).
REQ-017 Back-to-back grants SHALL be allowed every cycle, either requester.
REQ-018 Each grant SHALL produce exactly one mN_rvalid_o pulse to the granted requester RD_LAT cycles later (RD_LAT=0: same cycle), loads and stores alike.
REQ-019 Response routing SHALL use a RD_LAT-deep owner/valid/is-load shift register; mN_rdata_o = lsu_ld_data_i when owner=N and is-load, else 0.
REQ-020 Default arbitration: m0 priority; 8-bit wait counter increments each cycle m1_req_i=1 and m1_gnt_o=0, clears on m1 grant or m1_req_i=0.
REQ-021 When wait counter >= STARVE_LIM, m1 SHALL win the next contended cycle; counter saturates, never wraps.
REQ-022 Simultaneous requests, counter below limit: m0 granted, m1 waits.
REQ-023 A requester dropping mN_req_i before grant SHALL be legal; no response generated.

Reset
REQ-024 rst_ni low SHALL clear owner pipeline, wait counter, round-robin pointer immediately; all gnt/rvalid/lsu_wren_o = 0, rdata = 0.
REQ-025 Responses in flight at reset SHALL be discarded, never delivered after release.
REQ-026 First grant possible in the first clock edge cycle after rst_ni rises.

Configuration
REQ-027 Macro LSU_ARB_RR_EN defined: round-robin arbitration; 1-bit last-grant pointer, contended cycle grants the requester not granted last; pointer resets to m1 (m0 wins first contention); wait counter and STARVE_LIM unused.
REQ-028 Macro undefined: fixed priority with starvation guard per REQ-020..022.

Structure
REQ-029 Shared package lsu_pkg SHALL hold: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), requester-id enum (REQ_CORE, REQ_DMA), request struct (we, funct3, addr, wdata).
REQ-030 One sub-module lsu_arb_resp_pipe SHALL implement the owner/valid/is-load shift register parameterised by RD_LAT.

Verification
REQ-031 m0 load LW addr 0x0001_0000, RAM word 0xDEAD_BEEF, RD_LAT=1 -> m0_gnt_o cycle 0, m0_rvalid_o cycle 1, m0_rdata_o 0xDEAD_BEEF, m1 outputs 0.
REQ-032 m0 and m1 request every cycle, STARVE_LIM=8, macro off -> m0 granted 8 cycles, m1 granted cycle 8, m0 resumes cycle 9.
REQ-033 Macro on, both requesting continuously -> grants alternate m0,m1,m0,m1 starting m0.
REQ-034 m1 SW 0x1234_5678 to 0x0002_0000 then m0 LW same address next cycle -> lsu_wren_o=1 cycle 0; m1_rvalid_o rdata 0; m0 reads 0x0000_5678 in low half-word via LHU check and 0x1234_5678 via LW.
REQ-035 Grant load, assert rst_ni low before rvalid cycle -> no rvalid on either port during or after reset.
REQ-036 m1 requests 3 cycles then drops before grant (m0 busy) -> no m1 grant, no m1 rvalid, wait counter 0.
